// File: rtl/seg7_display_bank.sv
// -----------------------------------------------------------------------------
// seg7_display_bank
//
// Avalon-MM slave that holds NUM_DIGITS seven-segment digit registers and one
// control register. It drives all digits in parallel on seg_out and also
// time-multiplexes them onto seg_mux/digit_sel for scanned LED panels.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (CTRL at the all-ones address)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data (stored values, not decoded patterns)
//   seg_out     registered static segments, digit k at [7k+6:7k], bit0=a..bit6=g
//   seg_mux     registered segments of the digit currently being scanned
//   digit_sel   registered one-hot active-high scan enable
//
// CTRL layout
//   bit0                 DECODE      hex-decode DIGIT[k][3:0]
//   bit1                 BLANK       force every digit off
//   bit2                 ACTIVE_LOW  invert all segment outputs
//   [8+NUM_DIGITS-1:8]   BLINK_MASK  digits that blink with blink_phase
// -----------------------------------------------------------------------------
module seg7_display_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [6:0]              seg_mux,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int SCW  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = '1;
    localparam logic [SCW-1:0]        SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [BLW-1:0]        BLINK_LAST = BLW'(BLINK_DIV - 1);
    localparam logic [IDXW-1:0]       IDX_LAST   = IDXW'(NUM_DIGITS - 1);

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Register file
    logic [6:0]            digit_q [NUM_DIGITS];
    logic [6:0]            digit_d [NUM_DIGITS];
    logic [2:0]            ctrl_q, ctrl_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;

    // Timers
    logic [SCW-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IDXW-1:0]       scan_idx_q, scan_idx_d;
    logic [BLW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    // Output registers
    logic [7*NUM_DIGITS-1:0] seg_out_q, seg_out_d;
    logic [6:0]              seg_mux_q, seg_mux_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic [6:0]  seg_pat [NUM_DIGITS];
    logic [31:0] ctrl_rd;
    logic        wr_en;
    logic        wdata_unused;

    // Only a subset of writedata bits land in registers.
    assign wdata_unused = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // Register writes
    always_comb begin
        digit_d = digit_q;
        ctrl_d  = ctrl_q;
        mask_d  = mask_q;
        if (wr_en) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (address == ADDR_WIDTH'(k)) begin
                    digit_d[k] = writedata[6:0];
                end
            end
            if (address == CTRL_ADDR) begin
                ctrl_d = writedata[2:0];
                mask_d = writedata[8 +: NUM_DIGITS];
            end
        end
    end

    // Read mux; unmapped addresses fall through to zero.
    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[2:0]            = ctrl_q;
        ctrl_rd[8 +: NUM_DIGITS] = mask_q;
        readdata                = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (address == ADDR_WIDTH'(k)) begin
                readdata = {25'd0, digit_q[k]};
            end
        end
        if (address == CTRL_ADDR) begin
            readdata = ctrl_rd;
        end
    end

    // Scan and blink prescalers
    always_comb begin
        scan_cnt_d    = scan_cnt_q + 1'b1;
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Segment patterns: decode, then blank/blink, then polarity.
    always_comb begin
        logic [6:0] raw;
        logic [6:0] pat;
        logic       off;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            raw = ctrl_q[0] ? hex_to_seg(digit_q[k][3:0]) : digit_q[k];
            off = ctrl_q[1] | (mask_q[k] & blink_phase_q);
            pat = off ? 7'h00 : raw;
            seg_pat[k] = ctrl_q[2] ? ~pat : pat;
        end
    end

    // seg_mux and digit_sel follow the index being entered this edge so the
    // two stay aligned; a write on that same edge shows one cycle later.
    always_comb begin
        seg_out_d   = '0;
        seg_mux_d   = '0;
        digit_sel_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_out_d[7*k +: 7] = seg_pat[k];
            if (scan_idx_d == IDXW'(k)) begin
                seg_mux_d      = seg_pat[k];
                digit_sel_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_q[k] <= '0;
            end
            ctrl_q        <= '0;
            mask_q        <= '0;
            scan_cnt_q    <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_out_q     <= '0;
            seg_mux_q     <= '0;
            digit_sel_q   <= NUM_DIGITS'(1);
        end else begin
            digit_q       <= digit_d;
            ctrl_q        <= ctrl_d;
            mask_q        <= mask_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_out_q     <= seg_out_d;
            seg_mux_q     <= seg_mux_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    assign seg_out   = seg_out_q;
    assign seg_mux   = seg_mux_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seg7_display_bank.sv
module tb_seg7_display_bank;

    localparam int ND = 4;
    localparam int AW = 4;
    localparam int SD = 4;
    localparam int BD = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [AW-1:0] address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [7*ND-1:0] seg_out;
    logic [6:0]    seg_mux;
    logic [ND-1:0] digit_sel;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg7_display_bank #(
        .NUM_DIGITS(ND), .ADDR_WIDTH(AW), .SCAN_DIV(SD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .seg_out(seg_out), .seg_mux(seg_mux),
        .digit_sel(digit_sel)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        address = a;
        #1;
    endtask

    // Releases on a falling edge, so the next rising edge is edge 1.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (seg_out !== '0) begin tests_failed++; $display("FAIL reset_seg_out: got %h want 0", seg_out); end
        tests_run++;
        if (seg_mux !== 7'h00) begin tests_failed++; $display("FAIL reset_seg_mux: got %h want 0", seg_mux); end
        tests_run++;
        if (digit_sel !== 4'b0001) begin tests_failed++; $display("FAIL reset_digit_sel: got %b want 0001", digit_sel); end
        for (int a = 0; a < 16; a++) begin
            rd(AW'(a));
            tests_run++;
            if (readdata !== 32'h0) begin tests_failed++; $display("FAIL reset_readdata[%0d]: got %h want 0", a, readdata); end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_write_raw();
        do_reset();
        wr(4'd1, 32'hFFFF_FF7F);
        tests_run++;
        if (seg_out[13:7] !== 7'h00) begin tests_failed++; $display("FAIL raw_latency_early: got %h want 00", seg_out[13:7]); end
        tick();
        tests_run++;
        if (seg_out[13:7] !== 7'h7F) begin tests_failed++; $display("FAIL raw_digit1: got %h want 7f", seg_out[13:7]); end
        rd(4'd1);
        tests_run++;
        if (readdata !== 32'h7F) begin tests_failed++; $display("FAIL raw_readback1: got %h want 7f", readdata); end
    endtask

    task automatic test_decode();
        wr(4'd15, 32'h1);
        wr(4'd0, 32'hA5);
        rd(4'd0);
        tests_run++;
        if (readdata !== 32'h25) begin tests_failed++; $display("FAIL dec_readback0: got %h want 25", readdata); end
        rd(4'd15);
        tests_run++;
        if (readdata !== 32'h1) begin tests_failed++; $display("FAIL dec_ctrl_readback: got %h want 1", readdata); end
        tick();
        tests_run++;
        if (seg_out[6:0] !== 7'h6D) begin tests_failed++; $display("FAIL dec_digit0: got %h want 6d", seg_out[6:0]); end
        tests_run++;
        if (seg_out[13:7] !== 7'h71) begin tests_failed++; $display("FAIL dec_digit1: got %h want 71", seg_out[13:7]); end
        wr(4'd2, 32'h0E);
        tick();
        tests_run++;
        if (seg_out[20:14] !== 7'h79) begin tests_failed++; $display("FAIL dec_digit2: got %h want 79", seg_out[20:14]); end
        tests_run++;
        if (seg_out[27:21] !== 7'h3F) begin tests_failed++; $display("FAIL dec_digit3: got %h want 3f", seg_out[27:21]); end
    endtask

    task automatic test_active_low();
        do_reset();
        wr(4'd15, 32'h5);
        wr(4'd0, 32'h8);
        tick();
        tests_run++;
        if (seg_out[6:0] !== 7'h00) begin tests_failed++; $display("FAIL al_digit0: got %h want 00", seg_out[6:0]); end
        for (int k = 1; k < ND; k++) begin
            tests_run++;
            if (seg_out[7*k +: 7] !== 7'h40) begin tests_failed++; $display("FAIL al_digit%0d: got %h want 40", k, seg_out[7*k +: 7]); end
        end
        wr(4'd15, 32'h7);
        tests_run++;
        if (seg_out[13:7] !== 7'h40) begin tests_failed++; $display("FAIL al_blank_early: got %h want 40", seg_out[13:7]); end
        tick();
        tests_run++;
        if (seg_out !== 28'hFFF_FFFF) begin tests_failed++; $display("FAIL al_blank_all: got %h want fffffff", seg_out); end
        tests_run++;
        if (seg_mux !== 7'h7F) begin tests_failed++; $display("FAIL al_blank_mux: got %h want 7f", seg_mux); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_mux;
        logic [3:0] exp_sel;
        int idx;
        do_reset();
        wr(4'd0, 32'h01);
        wr(4'd1, 32'h02);
        wr(4'd2, 32'h04);
        wr(4'd3, 32'h08);
        for (int e = 5; e <= 20; e++) begin
            tick();
            idx = (e / SD) % ND;
            exp_sel = 4'b0001 << idx;
            exp_mux = 7'h01 << idx;
            tests_run++;
            if (digit_sel !== exp_sel) begin tests_failed++; $display("FAIL scan_sel e=%0d: got %b want %b", e, digit_sel, exp_sel); end
            tests_run++;
            if (seg_mux !== exp_mux) begin tests_failed++; $display("FAIL scan_mux e=%0d: got %h want %h", e, seg_mux, exp_mux); end
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp0;
        do_reset();
        wr(4'd15, 32'h0500);
        wr(4'd0, 32'h7F);
        wr(4'd2, 32'h7F);
        wr(4'd1, 32'h11);
        for (int e = 5; e <= 20; e++) begin
            tick();
            exp0 = (((e - 1) / BD) % 2 == 1) ? 7'h00 : 7'h7F;
            tests_run++;
            if (seg_out[6:0] !== exp0) begin tests_failed++; $display("FAIL blink_d0 e=%0d: got %h want %h", e, seg_out[6:0], exp0); end
            tests_run++;
            if (seg_out[20:14] !== exp0) begin tests_failed++; $display("FAIL blink_d2 e=%0d: got %h want %h", e, seg_out[20:14], exp0); end
            tests_run++;
            if ({seg_out[27:21], seg_out[13:7]} !== {7'h00, 7'h11}) begin
                tests_failed++; $display("FAIL blink_d13 e=%0d: got %h/%h want 00/11", e, seg_out[27:21], seg_out[13:7]);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (seg_out !== '0) begin tests_failed++; $display("FAIL blink_async_rst_seg: got %h want 0", seg_out); end
        tests_run++;
        if (digit_sel !== 4'b0001) begin tests_failed++; $display("FAIL blink_async_rst_sel: got %b want 0001", digit_sel); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wr(4'd15, 32'h0100);
        wr(4'd0, 32'h7F);
        for (int e = 3; e <= 10; e++) begin
            tick();
            exp0 = (((e - 1) / BD) % 2 == 1) ? 7'h00 : 7'h7F;
            tests_run++;
            if (seg_out[6:0] !== exp0) begin tests_failed++; $display("FAIL blink_restart e=%0d: got %h want %h", e, seg_out[6:0], exp0); end
        end
    endtask

    task automatic test_unmapped();
        do_reset();
        wr(4'd0, 32'h12);
        wr(4'd9, 32'hFFFF_FFFF);
        wr(4'd14, 32'hFFFF_FFFF);
        rd(4'd9);
        tests_run++;
        if (readdata !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read9: got %h want 0", readdata); end
        rd(4'd0);
        tests_run++;
        if (readdata !== 32'h12) begin tests_failed++; $display("FAIL unmapped_keep0: got %h want 12", readdata); end
        rd(4'd15);
        tests_run++;
        if (readdata !== 32'h0) begin tests_failed++; $display("FAIL unmapped_ctrl: got %h want 0", readdata); end
        tick();
        tests_run++;
        if (seg_out !== 28'h000_0012) begin tests_failed++; $display("FAIL unmapped_seg: got %h want 0000012", seg_out); end
        wr(4'd15, 32'hFFFF_FFFF);
        rd(4'd15);
        tests_run++;
        if (readdata !== 32'h0000_0F07) begin tests_failed++; $display("FAIL ctrl_all_bits: got %h want 00000f07", readdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick();
        tick();
        tick();
        wr(4'd1, 32'h5A);
        tests_run++;
        if (digit_sel !== 4'b0010) begin tests_failed++; $display("FAIL b2b_sel: got %b want 0010", digit_sel); end
        tests_run++;
        if (seg_mux !== 7'h00) begin tests_failed++; $display("FAIL b2b_mux_old: got %h want 00", seg_mux); end
        tick();
        tests_run++;
        if (seg_mux !== 7'h5A) begin tests_failed++; $display("FAIL b2b_mux_new: got %h want 5a", seg_mux); end
        tests_run++;
        if (seg_out[13:7] !== 7'h5A) begin tests_failed++; $display("FAIL b2b_seg_out: got %h want 5a", seg_out[13:7]); end
    endtask

    initial begin
        test_reset();
        test_write_raw();
        test_decode();
        test_active_low();
        test_scan();
        test_blink();
        test_unmapped();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
